// File: rtl/imm_pkg.sv
// Immediate format codes and range helpers shared by the encoder and the core's decoder.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_J = 3'b001,
        IMM_S = 3'b010,
        IMM_B = 3'b011,
        IMM_U = 3'b100
    } imm_type_e;

    localparam int unsigned IMM_I_W   = 12;
    localparam int unsigned IMM_S_W   = 12;
    localparam int unsigned IMM_B_W   = 13;
    localparam int unsigned IMM_J_W   = 21;
    localparam int unsigned IMM_U_LSB = 12;

    // True when v is representable as a w-bit two's-complement value.
    function automatic logic sign_fits(input logic [31:0] v, input int unsigned w);
        logic signed [31:0] s;
        s = $signed(v) >>> (w - 1);
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/imm_enc_if.sv
// Request and result handshake bundle of the immediate encoder.
interface imm_enc_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [31:0]       in_tmpl;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output in_valid, in_fmt, in_tmpl, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_addr
    );

    modport slave (
        input  in_valid, in_fmt, in_tmpl, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_addr
    );
endinterface

// File: rtl/imm_pack.sv
// Combinational packer: places the immediate into RV32I fields and range-checks it.
module imm_pack
    import imm_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [31:0] tmpl,
    input  logic [31:0] imm,
    output logic [31:0] inst,
    output logic        range_err
);

    always_comb begin
        inst      = tmpl;
        range_err = 1'b0;
        case (fmt)
            IMM_I: begin
                inst[31:20] = imm[11:0];
                range_err   = !sign_fits(imm, IMM_I_W);
            end
            IMM_S: begin
                inst[31:25] = imm[11:5];
                inst[11:7]  = imm[4:0];
                range_err   = !sign_fits(imm, IMM_S_W);
            end
            IMM_B: begin
                inst[31]    = imm[12];
                inst[30:25] = imm[10:5];
                inst[11:8]  = imm[4:1];
                inst[7]     = imm[11];
                range_err   = !sign_fits(imm, IMM_B_W) || imm[0];
            end
            IMM_U: begin
                inst[31:12] = imm[31:12];
                range_err   = (imm[IMM_U_LSB-1:0] != '0);
            end
            IMM_J: begin
                inst[31]    = imm[20];
                inst[30:21] = imm[10:1];
                inst[20]    = imm[11];
                inst[19:12] = imm[19:12];
                range_err   = !sign_fits(imm, IMM_J_W) || imm[0];
            end
            default: range_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_enc.sv
// Immediate encoder top: packer, sequential address tagging, error counter and 2-entry output FIFO.
module imm_enc
    import imm_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    imm_enc_if.slave             bus,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic [31:0]       pack_inst;
    logic              pack_err;
    logic [1:0]        count;
    logic [31:0]       head_inst, tail_inst;
    logic [ADDR_W-1:0] head_addr, tail_addr, addr_cnt;
    logic              accept, push, pop;

    imm_pack u_pack (
        .fmt       (bus.in_fmt),
        .tmpl      (bus.in_tmpl),
        .imm       (bus.in_imm),
        .inst      (pack_inst),
        .range_err (pack_err)
    );

    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_inst  = head_inst;
    assign bus.out_addr  = head_addr;

    assign accept = bus.in_valid && bus.in_ready;
    assign push   = accept && !pack_err;
    assign pop    = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            head_inst <= '0;
            head_addr <= BASE_ADDR;
            tail_inst <= '0;
            tail_addr <= BASE_ADDR;
            addr_cnt  <= BASE_ADDR;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else if (flush) begin
            count     <= '0;
            addr_cnt  <= BASE_ADDR;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= accept && pack_err;
            if (accept && pack_err && (err_count != '1))
                err_count <= err_count + 1'b1;
            if (push)
                addr_cnt <= addr_cnt + ADDR_W'(4);

            // Head is the registered output; a push lands in head whenever head is free or leaving.
            case (count)
                2'd0: if (push) begin
                    head_inst <= pack_inst;
                    head_addr <= addr_cnt;
                    count     <= 2'd1;
                end
                2'd1: begin
                    if (push && pop) begin
                        head_inst <= pack_inst;
                        head_addr <= addr_cnt;
                    end else if (push) begin
                        tail_inst <= pack_inst;
                        tail_addr <= addr_cnt;
                        count     <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                default: if (pop) begin
                    head_inst <= tail_inst;
                    head_addr <= tail_addr;
                    count     <= 2'd1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_enc.sv
// Directed self-checking bench for imm_enc: packing, range errors, backpressure, flush and async reset.
module tb_imm_enc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       err_pulse;
    logic [7:0] err_count;
    int         checks = 0;
    int         errors = 0;

    imm_enc_if #(.ADDR_W(32)) bus ();

    imm_enc #(
        .ADDR_W    (32),
        .BASE_ADDR (32'h0),
        .ERR_CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic req(input logic [2:0] fmt, input logic [31:0] tmpl, input logic [31:0] imm);
        int unsigned n = 0;
        bus.in_valid = 1'b1;
        bus.in_fmt   = fmt;
        bus.in_tmpl  = tmpl;
        bus.in_imm   = imm;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) check("req_accept", bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_fmt    = 3'b000;
        bus.in_tmpl   = '0;
        bus.in_imm    = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_inst", bus.out_inst, 0);
        check("rst_out_addr", bus.out_addr, 0);
        check("rst_err_pulse", err_pulse, 0);
        check("rst_err_count", err_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Packing of each format, streaming with out_ready high
        req(3'b000, 32'h0000_0093, 32'hFFFF_FFFF);
        check("i_valid", bus.out_valid, 1);
        check("i_inst", bus.out_inst, 32'hFFF0_0093);
        check("i_addr", bus.out_addr, 32'h0);
        req(3'b001, 32'h0000_00EF, 32'h0000_0800);
        check("j_inst", bus.out_inst, 32'h0010_00EF);
        check("j_addr", bus.out_addr, 32'h4);
        req(3'b011, 32'h0000_0063, 32'hFFFF_FFFC);
        check("b_inst", bus.out_inst, 32'hFE00_0EE3);
        check("b_addr", bus.out_addr, 32'h8);

        // Range errors
        req(3'b001, 32'h0000_00EF, 32'h0000_0003);
        check("jerr_pulse", err_pulse, 1);
        check("jerr_count", err_count, 1);
        check("jerr_no_valid", bus.out_valid, 0);
        @(negedge clk);
        check("jerr_pulse_drop", err_pulse, 0);
        req(3'b000, 32'h0000_0013, 32'h0000_0800);
        check("ierr_count", err_count, 2);
        req(3'b111, 32'h0000_0013, 32'h0000_0000);
        check("fmt_err_count", err_count, 3);

        // Good words after errors keep the unchanged address; fill FIFO
        bus.out_ready = 1'b0;
        req(3'b000, 32'h0000_0013, 32'h0000_0005);
        check("post_err_inst", bus.out_inst, 32'h0050_0013);
        check("post_err_addr", bus.out_addr, 32'hC);
        check("one_in_ready", bus.in_ready, 1);
        req(3'b010, 32'h0000_0023, 32'hFFFF_FFE1);
        check("full_in_ready", bus.in_ready, 0);
        check("full_head_addr", bus.out_addr, 32'hC);
        check("full_err_count", err_count, 3);

        // Flush with two words queued
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_valid", bus.out_valid, 0);
        check("flush_err_count", err_count, 0);
        check("flush_in_ready", bus.in_ready, 1);

        // Backpressure from BASE_ADDR
        req(3'b000, 32'h0000_0013, 32'h0000_0001);
        check("bp_a_addr", bus.out_addr, 32'h0);
        req(3'b000, 32'h0000_0013, 32'h0000_0002);
        check("bp_in_ready_low", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        bus.in_fmt   = 3'b000;
        bus.in_imm   = 32'h0000_0003;
        @(negedge clk);
        check("bp_hold_addr", bus.out_addr, 32'h0);
        check("bp_hold_inst", bus.out_inst, 32'h0010_0013);
        check("bp_still_full", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_pop1_addr", bus.out_addr, 32'h4);
        check("bp_pop1_inst", bus.out_inst, 32'h0020_0013);
        check("bp_pop1_ready", bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_c_addr", bus.out_addr, 32'h8);
        check("bp_c_inst", bus.out_inst, 32'h0030_0013);
        @(negedge clk);
        check("bp_drained", bus.out_valid, 0);

        // U-format packing and an async reset mid-burst
        bus.out_ready = 1'b0;
        req(3'b100, 32'h0000_0037, 32'h1234_5000);
        check("u_inst", bus.out_inst, 32'h1234_5037);
        check("u_addr", bus.out_addr, 32'hC);
        req(3'b100, 32'h0000_0037, 32'h1234_5001);
        check("uerr_count", err_count, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", bus.out_valid, 0);
        check("arst_in_ready", bus.in_ready, 1);
        check("arst_inst", bus.out_inst, 0);
        check("arst_addr", bus.out_addr, 0);
        check("arst_err_pulse", err_pulse, 0);
        check("arst_err_count", err_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req(3'b000, 32'h0000_0013, 32'h0000_0009);
        check("after_rst_addr", bus.out_addr, 32'h0);
        check("after_rst_inst", bus.out_inst, 32'h0090_0013);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
